// File: rtl/d_debounce_sync.sv
// Synchroniser plus consecutive-sample debouncer with registered level, rise/fall pulses and busy flag.
// Optional abort counter output glitch_cnt when D_DEBOUNCE_GLITCH_CNT_EN is defined.
module d_debounce_sync #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic       en,
  output logic       q,
  output logic       rise,
  output logic       fall,
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
  output logic       busy,
  output logic [7:0] glitch_cnt
`else
  output logic       busy
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_COUNTING = 1'b1;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  logic [0:0]             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   q_reg, q_next;
  logic                   rise_reg, fall_reg, busy_reg;
  logic                   abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // A reverting sample is checked before terminal count, so an abort always wins.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    q_next     = q_reg;
    abort      = 1'b0;
    case (state_reg)
      ST_STABLE: begin
        cnt_next = '0;
        if (s != q_reg && en) begin
          if (DEBOUNCE_CYCLES == 1) begin
            q_next = s;
          end else begin
            cnt_next   = CNT_ONE;
            state_next = ST_COUNTING;
          end
        end
      end
      ST_COUNTING: begin
        if (s == q_reg) begin
          cnt_next   = '0;
          state_next = ST_STABLE;
          abort      = 1'b1;
        end else if (en && cnt_reg == CNT_LAST) begin
          q_next     = s;
          cnt_next   = '0;
          state_next = ST_STABLE;
        end else if (en) begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_STABLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_STABLE;
      cnt_reg   <= '0;
      q_reg     <= RESET_LEVEL;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      q_reg     <= q_next;
      rise_reg  <= q_next & ~q_reg;
      fall_reg  <= ~q_next & q_reg;
      busy_reg  <= (state_next == ST_COUNTING);
    end
  end

  assign q    = q_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;
  assign busy = busy_reg;

`ifdef D_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      glitch_reg <= 8'd0;
    end else if (abort && glitch_reg != 8'hFF) begin
      glitch_reg <= glitch_reg + 8'd1;
    end
  end

  assign glitch_cnt = glitch_reg;
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_d_debounce_sync.sv
// Bench for d_debounce_sync: default instance plus a SYNC_STAGES=3, DEBOUNCE_CYCLES=1 instance.
// Expected pulses are queued by the stimulus and matched by a negedge monitor.
module tb_d_debounce_sync;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d = 1'b0, en = 1'b1, d2 = 1'b0, en2 = 1'b1;
  logic q, rise, fall, busy, q2, rise2, fall2, busy2;
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt, glitch_cnt2;
`endif

  d_debounce_sync dut (
    .clk(clk), .rst(rst), .d(d), .en(en),
    .q(q), .rise(rise), .fall(fall),
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
    .busy(busy), .glitch_cnt(glitch_cnt)
`else
    .busy(busy)
`endif
  );

  d_debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .d(d2), .en(en2),
    .q(q2), .rise(rise2), .fall(fall2),
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
    .busy(busy2), .glitch_cnt(glitch_cnt2)
`else
    .busy(busy2)
`endif
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    bit is_rise;
    int edge_no;
  } ev_t;

  ev_t sb0[$];
  ev_t sb1[$];
  int tests = 0;
  int fails = 0;
  int base;

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end else begin
      $display("[TB] ok   %s = %0d (edge %0d)", name, act, edge_cnt);
    end
  endtask

  task automatic push(int unit, bit is_rise, int e);
    ev_t ev;
    ev.is_rise = is_rise;
    ev.edge_no = e;
    if (unit == 0) sb0.push_back(ev);
    else sb1.push_back(ev);
  endtask

  task automatic wait_edge(int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  task automatic mon(int unit, logic r, logic f);
    ev_t ev;
    bit have;
    if (!(r || f)) return;
    tests++;
    have = 1'b0;
    if (unit == 0) begin
      if (sb0.size() != 0) begin ev = sb0.pop_front(); have = 1'b1; end
    end else begin
      if (sb1.size() != 0) begin ev = sb1.pop_front(); have = 1'b1; end
    end
    if (r && f) begin
      fails++;
      $display("[TB] FAIL pulse%0d: rise and fall both high at edge %0d", unit, edge_cnt);
    end else if (!have) begin
      fails++;
      $display("[TB] FAIL pulse%0d: unexpected %s at edge %0d, none required", unit,
               r ? "rise" : "fall", edge_cnt);
    end else if (ev.is_rise != r || ev.edge_no != edge_cnt) begin
      fails++;
      $display("[TB] FAIL pulse%0d: got %s at edge %0d, expected %s at edge %0d", unit,
               r ? "rise" : "fall", edge_cnt, ev.is_rise ? "rise" : "fall", ev.edge_no);
    end else begin
      $display("[TB] ok   pulse%0d %s at edge %0d", unit, r ? "rise" : "fall", edge_cnt);
    end
  endtask

  always @(negedge clk) begin
    mon(0, rise, fall);
    mon(1, rise2, fall2);
  end

  // Release d on the default instance and expect fall 18 edges later.
  task automatic release_d();
    base = edge_cnt;
    d = 1'b0;
    push(0, 1'b0, base + 18);
    wait_edge(base + 17);
    check("release_q_before", q, 1);
    wait_edge(base + 18);
    check("release_q_after", q, 0);
    wait_edge(base + 22);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with d high
    rst = 1'b0; d = 1'b1; d2 = 1'b1; en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_q", q, 0);
    check("reset_rise", rise, 0);
    check("reset_fall", fall, 0);
    check("reset_busy", busy, 0);
    check("reset_q2", q2, 0);
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
    check("reset_glitch", glitch_cnt, 0);
`endif
    d = 1'b0; d2 = 1'b0; rst = 1'b1;
    base = edge_cnt;
    wait_edge(base + 20);
    check("post_reset_q", q, 0);
    check("post_reset_busy", busy, 0);

    // Clean press
    base = edge_cnt;
    d = 1'b1;
    push(0, 1'b1, base + 18);
    wait_edge(base + 2);
    check("press_busy_e2", busy, 0);
    wait_edge(base + 3);
    check("press_busy_e3", busy, 1);
    wait_edge(base + 17);
    check("press_q_e17", q, 0);
    wait_edge(base + 18);
    check("press_q_e18", q, 1);
    check("press_rise_e18", rise, 1);
    wait_edge(base + 19);
    check("press_rise_e19", rise, 0);
    check("press_busy_e19", busy, 0);
    wait_edge(base + 25);
    release_d();

    // Bounce: 5 high, 3 low, then held high
    base = edge_cnt;
    d = 1'b1;
    wait_edge(base + 5);
    d = 1'b0;
    wait_edge(base + 8);
    d = 1'b1;
    push(0, 1'b1, base + 26);
    wait_edge(base + 9);
    check("bounce_busy_abort", busy, 0);
    wait_edge(base + 25);
    check("bounce_q_e25", q, 0);
    wait_edge(base + 26);
    check("bounce_q_e26", q, 1);
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
    check("bounce_glitch", glitch_cnt, 1);
`endif
    wait_edge(base + 30);
    release_d();

    // Enable high on odd edges only
    base = edge_cnt;
    d = 1'b1;
    push(0, 1'b1, base + 33);
    for (int k = 1; k <= 34; k++) begin
      wait_edge(base + k - 1);
      en = (k % 2 == 1);
      if (k == 4) check("en_busy_e3", busy, 1);
      if (k == 33) check("en_q_e32", q, 0);
    end
    check("en_q_e33", q, 1);
    en = 1'b1;
    wait_edge(base + 36);
    release_d();

    // Reset in the middle of a count
    base = edge_cnt;
    d = 1'b1;
    wait_edge(base + 10);
    check("midrst_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    check("midrst_q", q, 0);
    check("midrst_busy", busy, 0);
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
    check("midrst_glitch", glitch_cnt, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    base = edge_cnt;
    push(0, 1'b1, base + 18);
    wait_edge(base + 17);
    check("midrst_q_e17", q, 0);
    wait_edge(base + 18);
    check("midrst_q_e18", q, 1);
    wait_edge(base + 20);
    release_d();

    // DEBOUNCE_CYCLES=1, SYNC_STAGES=3 instance
    base = edge_cnt;
    d2 = 1'b1;
    push(1, 1'b1, base + 4);
    wait_edge(base + 3);
    check("fast_q_e3", q2, 0);
    wait_edge(base + 4);
    check("fast_q_e4", q2, 1);
    check("fast_busy", busy2, 0);
    wait_edge(base + 9);
    d2 = 1'b0;
    push(1, 1'b0, base + 13);
    push(1, 1'b1, base + 14);
    wait_edge(base + 10);
    d2 = 1'b1;
    wait_edge(base + 13);
    check("fast_glitch_q_e13", q2, 0);
    wait_edge(base + 14);
    check("fast_glitch_q_e14", q2, 1);
    wait_edge(base + 16);
    base = edge_cnt;
    d2 = 1'b0;
    push(1, 1'b0, base + 4);
    wait_edge(base + 6);
    check("fast_release_q", q2, 0);

    check("sb0_drained", 8'(sb0.size()), 0);
    check("sb1_drained", 8'(sb1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
